// File: rtl/scsi_bus_arbiter.sv
// Shares the SCSI local bus between host slave cycles and chip DMA with alternating priority; registered outputs, slv_req->cs 1 edge, async pins +2 sync edges.
// Slave cycles are stretched (no DTACK) while DMA owns the bus. Define SCSI_ARB_WATCHDOG_EN to add the SLACK timeout and bus error.
module scsi_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic CLK,
    input  logic RESET,
    input  logic slv_req,
    input  logic SLACK_n,
    input  logic SCSI_BR_n,
    input  logic SCSI_BGACK_n,
    output logic scsi_cs,
    output logic slv_dtack,
    output logic slv_berr,
    output logic SCSI_BG_n,
    output logic dma_active
);

    typedef enum logic [2:0] {
        IDLE,
        SLV_WAIT,
        SLV_ACK,
        SLV_ERR,
        SLV_END,
        DMA_GRANT,
        DMA_OWN,
        DMA_END
    } state_t;

    typedef enum logic {
        OWNER_SLV,
        OWNER_DMA
    } owner_t;

    state_t     state;
    owner_t     last_owner;
    logic [1:0] slack_sync;
    logic [1:0] br_sync;
    logic [1:0] bgack_sync;
    logic       slack_low;
    logic       br_pend;
    logic       bgack_low;

    // Synchronizers idle at the inactive (high) level so reset never looks like a request.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            slack_sync <= 2'b11;
            br_sync    <= 2'b11;
            bgack_sync <= 2'b11;
        end else begin
            slack_sync <= {slack_sync[0], SLACK_n};
            br_sync    <= {br_sync[0], SCSI_BR_n};
            bgack_sync <= {bgack_sync[0], SCSI_BGACK_n};
        end
    end

    assign slack_low = ~slack_sync[1];
    assign br_pend   = ~br_sync[1];
    assign bgack_low = ~bgack_sync[1];

`ifdef SCSI_ARB_WATCHDOG_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd_cnt;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign slv_berr       = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            last_owner <= OWNER_DMA;
            scsi_cs    <= 1'b0;
            slv_dtack  <= 1'b0;
            SCSI_BG_n  <= 1'b1;
            dma_active <= 1'b0;
`ifdef SCSI_ARB_WATCHDOG_EN
            slv_berr   <= 1'b0;
            wd_cnt     <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // On a tie the requester that did not own the bus last goes first.
                    if (slv_req && (!br_pend || last_owner == OWNER_DMA)) begin
                        state   <= SLV_WAIT;
                        scsi_cs <= 1'b1;
                    end else if (br_pend) begin
                        state     <= DMA_GRANT;
                        SCSI_BG_n <= 1'b0;
                    end
                end
                SLV_WAIT: begin
`ifdef SCSI_ARB_WATCHDOG_EN
                    wd_cnt <= wd_cnt + 8'd1;
`endif
                    if (slack_low) begin
                        state     <= SLV_ACK;
                        slv_dtack <= 1'b1;
                    end else if (!slv_req) begin
                        state   <= SLV_END;
                        scsi_cs <= 1'b0;
`ifdef SCSI_ARB_WATCHDOG_EN
                    end else if (wd_cnt == TIMEOUT_LAST) begin
                        state    <= SLV_ERR;
                        scsi_cs  <= 1'b0;
                        slv_berr <= 1'b1;
`endif
                    end
                end
                SLV_ACK: begin
                    if (!slv_req) begin
                        state     <= SLV_END;
                        scsi_cs   <= 1'b0;
                        slv_dtack <= 1'b0;
                    end
                end
`ifdef SCSI_ARB_WATCHDOG_EN
                SLV_ERR: begin
                    if (!slv_req) begin
                        state    <= SLV_END;
                        slv_berr <= 1'b0;
                    end
                end
`endif
                SLV_END: begin
                    state      <= IDLE;
                    last_owner <= OWNER_SLV;
`ifdef SCSI_ARB_WATCHDOG_EN
                    wd_cnt     <= 8'd0;
`endif
                end
                DMA_GRANT: begin
                    if (bgack_low) begin
                        state      <= DMA_OWN;
                        SCSI_BG_n  <= 1'b1;
                        dma_active <= 1'b1;
                    end else if (!br_pend) begin
                        state     <= DMA_END;
                        SCSI_BG_n <= 1'b1;
                    end
                end
                DMA_OWN: begin
                    if (!bgack_low) begin
                        state      <= DMA_END;
                        dma_active <= 1'b0;
                    end
                end
                DMA_END: begin
                    state      <= IDLE;
                    last_owner <= OWNER_DMA;
                end
                default: begin
                    state      <= IDLE;
                    scsi_cs    <= 1'b0;
                    slv_dtack  <= 1'b0;
                    SCSI_BG_n  <= 1'b1;
                    dma_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scsi_bus_arbiter.sv
// Directed cycle-by-cycle vectors for scsi_bus_arbiter plus watchdog sequences.
module tb_scsi_bus_arbiter;

    logic CLK = 1'b0;
    logic RESET;
    logic slv_req;
    logic SLACK_n;
    logic SCSI_BR_n;
    logic SCSI_BGACK_n;
    logic scsi_cs;
    logic slv_dtack;
    logic slv_berr;
    logic SCSI_BG_n;
    logic dma_active;
    logic [4:0] outs;

    int total = 0;
    int bad   = 0;

    // stim = {RESET, slv_req, SLACK_n, SCSI_BR_n, SCSI_BGACK_n}
    // expo = {scsi_cs, slv_dtack, slv_berr, SCSI_BG_n, dma_active}
    typedef struct {
        logic [4:0] stim;
        logic [4:0] expo;
    } vec_t;

    vec_t vecs[$];

    scsi_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .slv_req      (slv_req),
        .SLACK_n      (SLACK_n),
        .SCSI_BR_n    (SCSI_BR_n),
        .SCSI_BGACK_n (SCSI_BGACK_n),
        .scsi_cs      (scsi_cs),
        .slv_dtack    (slv_dtack),
        .slv_berr     (slv_berr),
        .SCSI_BG_n    (SCSI_BG_n),
        .dma_active   (dma_active)
    );

    assign outs = {scsi_cs, slv_dtack, slv_berr, SCSI_BG_n, dma_active};

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input logic [4:0] s, input logic [4:0] e);
        vec_t v;
        v.stim = s;
        v.expo = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got cs/dt/berr/bg_n/dma=%b want %b", name, got, want);
        end
    endtask

    initial begin
        RESET        = 1'b1;
        slv_req      = 1'b0;
        SLACK_n      = 1'b1;
        SCSI_BR_n    = 1'b1;
        SCSI_BGACK_n = 1'b1;

        // reset state
        add(5'b10111, 5'b00010); add(5'b10111, 5'b00010);
        // slave read, SLACK 5 cycles after cs, release
        add(5'b01111, 5'b10010); add(5'b01111, 5'b10010); add(5'b01111, 5'b10010);
        add(5'b01111, 5'b10010); add(5'b01111, 5'b10010);
        add(5'b01011, 5'b10010); add(5'b01011, 5'b10010); add(5'b01011, 5'b11010);
        add(5'b01011, 5'b11010); add(5'b00011, 5'b00010); add(5'b00111, 5'b00010);
        add(5'b00111, 5'b00010);
        // DMA: request, grant, own, release
        add(5'b00101, 5'b00010); add(5'b00101, 5'b00010); add(5'b00101, 5'b00000);
        add(5'b00100, 5'b00000); add(5'b00100, 5'b00000); add(5'b00110, 5'b00011);
        add(5'b00110, 5'b00011); add(5'b00111, 5'b00011); add(5'b00111, 5'b00011);
        add(5'b00111, 5'b00010); add(5'b00111, 5'b00010);
        // tie after DMA -> slave; new slave cycle ties with BR after slave -> DMA
        add(5'b00101, 5'b00010); add(5'b00101, 5'b00010); add(5'b01101, 5'b10010);
        add(5'b01001, 5'b10010); add(5'b01001, 5'b10010); add(5'b01001, 5'b11010);
        add(5'b00001, 5'b00010); add(5'b01101, 5'b00010); add(5'b01101, 5'b00000);
        // slv_req waits through DMA_OWN, then ties with new BR -> slave
        add(5'b01100, 5'b00000); add(5'b01110, 5'b00000); add(5'b01110, 5'b00011);
        add(5'b01100, 5'b00011); add(5'b01101, 5'b00011); add(5'b01101, 5'b00011);
        add(5'b01101, 5'b00010); add(5'b01101, 5'b00010); add(5'b01101, 5'b10010);
        add(5'b01101, 5'b10010);
        // slave abort
        add(5'b00111, 5'b00010); add(5'b00111, 5'b00010); add(5'b00111, 5'b00010);
        // reset in DMA_OWN
        add(5'b00101, 5'b00010); add(5'b00101, 5'b00010); add(5'b00101, 5'b00000);
        add(5'b00100, 5'b00000); add(5'b00100, 5'b00000); add(5'b00100, 5'b00011);
        add(5'b10100, 5'b00010); add(5'b00111, 5'b00010);
        // reset in SLV_ACK
        add(5'b01111, 5'b10010); add(5'b01011, 5'b10010); add(5'b01011, 5'b10010);
        add(5'b01011, 5'b11010); add(5'b11011, 5'b00010); add(5'b00111, 5'b00010);
        // BR withdrawn during DMA_GRANT
        add(5'b00101, 5'b00010); add(5'b00101, 5'b00010); add(5'b00101, 5'b00000);
        add(5'b00111, 5'b00000); add(5'b00111, 5'b00000); add(5'b00111, 5'b00010);
        add(5'b00111, 5'b00010);

        for (int k = 0; k < vecs.size(); k++) begin
            {RESET, slv_req, SLACK_n, SCSI_BR_n, SCSI_BGACK_n} = vecs[k].stim;
            tick();
            check($sformatf("vec%0d", k), outs, vecs[k].expo);
        end

        // SLACK never arrives
        slv_req = 1'b1;
        tick();
        check("wd_entry", outs, 5'b10010);
`ifdef SCSI_ARB_WATCHDOG_EN
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("wd_wait%0d", i), outs, 5'b10010);
        end
        tick();
        check("wd_berr", outs, 5'b00110);
        tick();
        check("wd_berr_hold", outs, 5'b00110);
        slv_req = 1'b0;
        tick();
        check("wd_end", outs, 5'b00010);
`else
        for (int i = 1; i <= 1000; i++) begin
            tick();
            check($sformatf("nowd_wait%0d", i), outs, 5'b10010);
        end
        slv_req = 1'b0;
        tick();
        check("nowd_end", outs, 5'b00010);
`endif
        tick();
        check("final_idle", outs, 5'b00010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
